// File: rtl/tff_seq_pkg.sv
// ============================================================================
// Module  : tff_seq_pkg
// Brief   : Shared state/mode constants and toggle-vector helper for the
//           T flip-flop bank sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package tff_seq_pkg;

    localparam int MAX_WIDTH = 16;

    typedef logic [1:0] state_t;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic MODE_UP = 1'b0;
    localparam logic MODE_DN = 1'b1;

    // Bit i toggles when every lower bit is 1 (carry) or every lower bit is 0 (borrow).
    function automatic logic [MAX_WIDTH-1:0] step_toggles(
        input logic [MAX_WIDTH-1:0] cnt,
        input logic                 md
    );
        logic [MAX_WIDTH-1:0] tv;
        logic                 chain;
        tv    = '0;
        tv[0] = 1'b1;
        chain = 1'b1;
        for (int i = 1; i < MAX_WIDTH; i++) begin
            chain = chain & ((md == MODE_DN) ? ~cnt[i-1] : cnt[i-1]);
            tv[i] = chain;
        end
        return tv;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tff_seq_ctrl_cell.sv
// ============================================================================
// Module  : tff_cell
// Brief   : Single T flip-flop, asynchronous active-low reset to 0.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tff_seq_ctrl.sv
// ============================================================================
// Module  : tff_seq_ctrl
// Brief   : Loads a T flip-flop bank with a start value, then counts it up or
//           down to a programmed end value. Optional macro TFF_SEQ_PAUSE_EN
//           adds a pause input that stalls counting in RUN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tff_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
`ifdef TFF_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    import tff_seq_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic             mode_q;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] start_value;
    logic [WIDTH-1:0] end_value;
    logic             at_end;
    logic             hold;

`ifdef TFF_SEQ_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign start_value = (mode_q == MODE_DN) ? limit_q : '0;
    assign end_value   = (mode_q == MODE_DN) ? '0 : limit_q;
    assign at_end      = (count == end_value);

    always_comb begin
        t_vec     = '0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                t_vec     = count ^ start_value;
                state_nxt = RUN;
            end
            RUN: begin
                // End check wins over pause and precedes any step, so no wrap.
                if (at_end) begin
                    state_nxt = DONE;
                end else if (!hold) begin
                    t_vec = WIDTH'(step_toggles(MAX_WIDTH'(count), mode_q));
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mode_q  <= MODE_UP;
            limit_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                mode_q  <= mode;
                limit_q <= limit;
            end
        end
    end

    assign busy = (state == LOAD) || (state == RUN);
    assign done = (state == DONE);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bank
            tff_cell u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .t     (t_vec[i]),
                .q     (count[i])
            );
        end
    endgenerate

endmodule

`default_nettype wire
